// File: rtl/bsg_mcl_host_link_pkg.sv
// Shared types and constants for the manycore host link: packet layouts,
// opcodes and the per-channel flow-control state encoding.
package bsg_mcl_host_link_pkg;

  localparam logic [7:0]  FENCE_OP = 8'hFF;
  localparam int unsigned op_lsb   = 88;

  typedef enum logic [7:0] {
    ePacketOp_remote_load  = 8'h00,
    ePacketOp_remote_store = 8'h01,
    ePacketOp_remote_sw    = 8'h02,
    ePacketOp_remote_amo   = 8'h03
  } bsg_mcl_packet_op_e;

  // 128-bit host FIFO request; op must sit at op_lsb
  typedef struct packed {
    logic [31:0]        rsvd;
    bsg_mcl_packet_op_e op;
    logic [23:0]        tag;
    logic [31:0]        addr;
    logic [31:0]        payload;
  } bsg_mcl_request_s;

  typedef struct packed {
    logic [87:0]        rsvd;
    bsg_mcl_packet_op_e op;
    logic [31:0]        data;
  } bsg_mcl_response_s;

  typedef enum logic {
    eChanIdle  = 1'b0,
    eChanDrain = 1'b1
  } chan_state_e;

endpackage

// File: rtl/bsg_mcl_host_link_chan.sv
// One host-link channel: admission against credits and response-slot
// reservations, host fence drain, and write-ack generation for inbound stores.
module bsg_mcl_host_link_chan
  import bsg_mcl_host_link_pkg::*;
#(
  parameter int unsigned fifo_width_p      = 128,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned rsp_fifo_els_p    = 32,
  parameter int unsigned max_out_credits_p = 16,
  parameter int unsigned reserve_mode_p    = 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   host_req_v_i,
  input  logic [fifo_width_p-1:0]                host_req_data_i,
  output logic                                   host_req_ready_o,
  output logic                                   ep_out_v_o,
  output logic [fifo_width_p-1:0]                ep_out_data_o,
  input  logic                                   ep_out_ready_i,
  input  logic [$clog2(max_out_credits_p+1)-1:0] ep_out_credits_i,
  input  logic                                   rsp_deq_i,
  input  logic [$clog2(rsp_fifo_els_p+1)-1:0]    rsp_vacancy_i,
  input  logic                                   mc_req_v_i,
  input  logic                                   mc_req_we_i,
  input  logic                                   mc_req_ready_i,
  output logic                                   mc_req_yumi_o,
  input  logic                                   host_rsp_v_i,
  input  logic [data_width_p-1:0]                host_rsp_data_i,
  output logic                                   host_rsp_ready_o,
  output logic                                   ep_returning_v_o,
  output logic [data_width_p-1:0]                ep_returning_data_o,
  output logic [$clog2(rsp_fifo_els_p+1)-1:0]    loads_reserved_o,
  output logic                                   fence_busy_o
);

  localparam int unsigned cred_w_lp = $clog2(max_out_credits_p+1);
  localparam int unsigned rsp_w_lp  = $clog2(rsp_fifo_els_p+1);

  chan_state_e         state_r, state_n;
  logic [rsp_w_lp-1:0] loads_reserved_r;
  logic                wr_ack_r;
  logic [7:0]          op;
  logic                is_fence, is_load, load_block, enable, load_acc;

  // Request decode and admission condition
  always_comb begin
    op       = host_req_data_i[op_lsb +: 8];
    is_fence = (op == FENCE_OP);
    is_load  = (op == 8'(ePacketOp_remote_load));
    if (reserve_mode_p != 0)
      load_block = (loads_reserved_r >= rsp_w_lp'(rsp_fifo_els_p));
    else
      load_block = (32'(rsp_vacancy_i) < 32'(max_out_credits_p));
    enable   = (ep_out_credits_i != '0) && !(is_load && load_block);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eChanIdle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n          = state_r;
    host_req_ready_o = 1'b0;
    ep_out_v_o       = 1'b0;
    unique case (state_r)
      eChanIdle: begin
        if (is_fence) begin
          // fence is swallowed here and never reaches the endpoint
          host_req_ready_o = 1'b1;
          if (host_req_v_i) state_n = eChanDrain;
        end else begin
          ep_out_v_o       = host_req_v_i & enable;
          host_req_ready_o = ep_out_ready_i & enable;
        end
      end
      eChanDrain: begin
        if (ep_out_credits_i == cred_w_lp'(max_out_credits_p) && loads_reserved_r == '0)
          state_n = eChanIdle;
      end
      default: state_n = eChanIdle;
    endcase
  end

  assign ep_out_data_o = host_req_data_i;
  assign load_acc      = host_req_v_i & host_req_ready_o & is_load;

  // Outstanding response-slot reservations
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      loads_reserved_r <= '0;
    end else begin
      unique case ({load_acc, rsp_deq_i})
        2'b10:   loads_reserved_r <= loads_reserved_r + rsp_w_lp'(1);
        2'b01:   if (loads_reserved_r != '0) loads_reserved_r <= loads_reserved_r - rsp_w_lp'(1);
        default: loads_reserved_r <= loads_reserved_r;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   !(rsp_deq_i && loads_reserved_r == '0));

  assign mc_req_yumi_o = mc_req_v_i & mc_req_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) wr_ack_r <= 1'b0;
    else            wr_ack_r <= mc_req_yumi_o & mc_req_we_i;
  end

  // Write acks preempt host load replies on the returning path
  always_comb begin
    host_rsp_ready_o    = 1'b1;
    ep_returning_v_o    = host_rsp_v_i;
    ep_returning_data_o = host_rsp_data_i;
    if (wr_ack_r) begin
      host_rsp_ready_o    = 1'b0;
      ep_returning_v_o    = 1'b1;
      ep_returning_data_o = '0;
    end
  end

  assign loads_reserved_o = loads_reserved_r;
  assign fence_busy_o     = (state_r == eChanDrain);

endmodule

// File: rtl/bsg_mcl_host_link_ctrl.sv
// Host link flow-control controller: num_endpoint_p independent channels,
// each admitting host requests and returning write acks for its endpoint.
module bsg_mcl_host_link_ctrl
  import bsg_mcl_host_link_pkg::*;
#(
  parameter int unsigned num_endpoint_p    = 1,
  parameter int unsigned fifo_width_p      = 128,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned rsp_fifo_els_p    = 32,
  parameter int unsigned max_out_credits_p = 16,
  parameter int unsigned reserve_mode_p    = 1
) (
  input  logic                                                       clk_i,
  input  logic                                                       reset_n_i,
  input  logic [num_endpoint_p-1:0]                                  host_req_v_i,
  input  logic [num_endpoint_p-1:0][fifo_width_p-1:0]                host_req_data_i,
  output logic [num_endpoint_p-1:0]                                  host_req_ready_o,
  output logic [num_endpoint_p-1:0]                                  ep_out_v_o,
  output logic [num_endpoint_p-1:0][fifo_width_p-1:0]                ep_out_data_o,
  input  logic [num_endpoint_p-1:0]                                  ep_out_ready_i,
  input  logic [num_endpoint_p-1:0][$clog2(max_out_credits_p+1)-1:0] ep_out_credits_i,
  input  logic [num_endpoint_p-1:0]                                  rsp_deq_i,
  input  logic [num_endpoint_p-1:0][$clog2(rsp_fifo_els_p+1)-1:0]    rsp_vacancy_i,
  input  logic [num_endpoint_p-1:0]                                  mc_req_v_i,
  input  logic [num_endpoint_p-1:0]                                  mc_req_we_i,
  input  logic [num_endpoint_p-1:0]                                  mc_req_ready_i,
  output logic [num_endpoint_p-1:0]                                  mc_req_yumi_o,
  input  logic [num_endpoint_p-1:0]                                  host_rsp_v_i,
  input  logic [num_endpoint_p-1:0][data_width_p-1:0]                host_rsp_data_i,
  output logic [num_endpoint_p-1:0]                                  host_rsp_ready_o,
  output logic [num_endpoint_p-1:0]                                  ep_returning_v_o,
  output logic [num_endpoint_p-1:0][data_width_p-1:0]                ep_returning_data_o,
  output logic [num_endpoint_p-1:0][$clog2(rsp_fifo_els_p+1)-1:0]    loads_reserved_o,
  output logic [num_endpoint_p-1:0]                                  fence_busy_o
);

  for (genvar i = 0; i < num_endpoint_p; i++) begin : g_chan
    bsg_mcl_host_link_chan #(
      .fifo_width_p      (fifo_width_p),
      .data_width_p      (data_width_p),
      .rsp_fifo_els_p    (rsp_fifo_els_p),
      .max_out_credits_p (max_out_credits_p),
      .reserve_mode_p    (reserve_mode_p)
    ) u_chan (
      .clk_i               (clk_i),
      .reset_n_i           (reset_n_i),
      .host_req_v_i        (host_req_v_i[i]),
      .host_req_data_i     (host_req_data_i[i]),
      .host_req_ready_o    (host_req_ready_o[i]),
      .ep_out_v_o          (ep_out_v_o[i]),
      .ep_out_data_o       (ep_out_data_o[i]),
      .ep_out_ready_i      (ep_out_ready_i[i]),
      .ep_out_credits_i    (ep_out_credits_i[i]),
      .rsp_deq_i           (rsp_deq_i[i]),
      .rsp_vacancy_i       (rsp_vacancy_i[i]),
      .mc_req_v_i          (mc_req_v_i[i]),
      .mc_req_we_i         (mc_req_we_i[i]),
      .mc_req_ready_i      (mc_req_ready_i[i]),
      .mc_req_yumi_o       (mc_req_yumi_o[i]),
      .host_rsp_v_i        (host_rsp_v_i[i]),
      .host_rsp_data_i     (host_rsp_data_i[i]),
      .host_rsp_ready_o    (host_rsp_ready_o[i]),
      .ep_returning_v_o    (ep_returning_v_o[i]),
      .ep_returning_data_o (ep_returning_data_o[i]),
      .loads_reserved_o    (loads_reserved_o[i]),
      .fence_busy_o        (fence_busy_o[i])
    );
  end

endmodule
